// File: rtl/aes_encipher.sv
// AES-128 encipher datapath: one round per clock, with the S-box and the
// key schedule supplied from outside the block.
module aes_encipher (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] block_in,
    input  logic [127:0] key,
    input  logic         key_ready,
    input  logic [127:0] round_key_1,
    input  logic [127:0] round_key_2,
    input  logic [127:0] round_key_3,
    input  logic [127:0] round_key_4,
    input  logic [127:0] round_key_5,
    input  logic [127:0] round_key_6,
    input  logic [127:0] round_key_7,
    input  logic [127:0] round_key_8,
    input  logic [127:0] round_key_9,
    input  logic [127:0] round_key_10,
    output logic [127:0] sboxw,
    input  logic [127:0] new_sboxw,
    output logic [127:0] block_out,
    output logic         ready
);

    typedef enum logic {IDLE, ROUND} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [3:0]   rc_reg;
    logic [127:0] state_reg;
    logic [127:0] block_out_reg;
    logic         ready_reg;

    logic         accept;
    logic         round_step;
    logic         last_round;
    logic [127:0] rk_sel;
    logic [127:0] shifted;
    logic [127:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign sboxw     = state_reg;
    assign block_out = block_out_reg;
    assign ready     = ready_reg;

    // Bytes are column-major: byte index = row + 4*col, byte 0 in the MSBs.
    // Row r of the output takes column (c + r) mod 4 of the input.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift_rows
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign shifted[127 - 8*gi -: 8] = new_sboxw[127 - 8*SRC -: 8];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_mix_columns
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shifted[127 - 32*gi -: 8];
            assign a1 = shifted[119 - 32*gi -: 8];
            assign a2 = shifted[111 - 32*gi -: 8];
            assign a3 = shifted[103 - 32*gi -: 8];
            // 3*x is xtime(x) ^ x.
            assign mixed[127 - 32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mixed[119 - 32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mixed[111 - 32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mixed[103 - 32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    always_comb begin
        rk_sel = round_key_10;
        case (rc_reg)
            4'd1:    rk_sel = round_key_1;
            4'd2:    rk_sel = round_key_2;
            4'd3:    rk_sel = round_key_3;
            4'd4:    rk_sel = round_key_4;
            4'd5:    rk_sel = round_key_5;
            4'd6:    rk_sel = round_key_6;
            4'd7:    rk_sel = round_key_7;
            4'd8:    rk_sel = round_key_8;
            4'd9:    rk_sel = round_key_9;
            default: rk_sel = round_key_10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:    if (start && key_ready) fsm_next = ROUND;
            ROUND:   if (rc_reg == 4'd10)    fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        accept     = (fsm_reg == IDLE) && start && key_ready;
        round_step = (fsm_reg == ROUND);
        last_round = round_step && (rc_reg == 4'd10);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            rc_reg        <= 4'd0;
            state_reg     <= '0;
            block_out_reg <= '0;
            ready_reg     <= 1'b0;
        end else if (accept) begin
            state_reg <= block_in ^ key;
            rc_reg    <= 4'd1;
            ready_reg <= 1'b0;
        end else if (last_round) begin
            block_out_reg <= shifted ^ rk_sel;
            ready_reg     <= 1'b1;
            rc_reg        <= 4'd0;
        end else if (round_step) begin
            state_reg <= mixed ^ rk_sel;
            rc_reg    <= rc_reg + 4'd1;
        end
    end

endmodule

// File: tb/tb_aes_encipher.sv
// Directed known-answer bench for aes_encipher; the bench supplies the S-box
// and the expanded round keys that the design expects from its neighbours.
module tb_aes_encipher;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] block_in;
    logic [127:0] key;
    logic         key_ready;
    logic [127:0] rk [0:10];
    logic [127:0] sboxw;
    logic [127:0] new_sboxw;
    logic [127:0] block_out;
    logic         ready;

    logic [7:0]   sbox_tab [0:255];
    int           n_cmp = 0;
    int           n_bad = 0;

    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_encipher dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .block_in     (block_in),
        .key          (key),
        .key_ready    (key_ready),
        .round_key_1  (rk[1]),
        .round_key_2  (rk[2]),
        .round_key_3  (rk[3]),
        .round_key_4  (rk[4]),
        .round_key_5  (rk[5]),
        .round_key_6  (rk[6]),
        .round_key_7  (rk[7]),
        .round_key_8  (rk[8]),
        .round_key_9  (rk[9]),
        .round_key_10 (rk[10]),
        .sboxw        (sboxw),
        .new_sboxw    (new_sboxw),
        .block_out    (block_out),
        .ready        (ready)
    );

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = gf_xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the field inverse plus the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++) begin
            if (gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    always_comb begin
        new_sboxw = '0;
        for (int i = 0; i < 16; i++) begin
            new_sboxw[127 - 8*i -: 8] = sbox_tab[sboxw[127 - 8*i -: 8]];
        end
    end

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where ready is seen.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] ct, input int inject_at);
        int low_cnt = 0;
        expand_key(k);
        block_in  = pt;
        key       = k;
        key_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, " initial state"}, sboxw, pt ^ k);
        while (!ready && low_cnt < 30) begin
            low_cnt++;
            start = (low_cnt == inject_at);
            if (low_cnt == inject_at) block_in = ~pt;
            @(negedge clk);
        end
        start    = 1'b0;
        block_in = pt;
        check_eq({tag, " ready low cycles"}, 128'(low_cnt), 128'd10);
        check_eq({tag, " ciphertext"}, block_out, ct);
    endtask

    initial begin
        logic [127:0] sb0;
        logic         seen_ready;
        logic         sb_moved;

        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        reset_n   = 1'b1;
        start     = 1'b0;
        key_ready = 1'b0;
        block_in  = '0;
        key       = '0;
        expand_key('0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset ready", 128'(ready), 128'd0);
        check_eq("reset block_out", block_out, '0);
        check_eq("reset sboxw", sboxw, '0);
        reset_n = 1'b0;

        // Requests without key_ready must be ignored.
        block_in   = C1_PT;
        key        = C1_KEY;
        start      = 1'b1;
        sb0        = sboxw;
        seen_ready = 1'b0;
        sb_moved   = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ready) seen_ready = 1'b1;
            if (sboxw !== sb0) sb_moved = 1'b1;
        end
        start = 1'b0;
        check_eq("gated ready", 128'(seen_ready), 128'd0);
        check_eq("gated sboxw", 128'(sb_moved), 128'd0);

        run_block("zero", '0, '0, ZERO_CT, 0);
        run_block("c1", C1_PT, C1_KEY, C1_CT, 0);

        // Second request mid-operation must not disturb the first.
        run_block("busy", '0, '0, ZERO_CT, 5);
        seen_ready = 1'b1;
        sb_moved   = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (!ready) seen_ready = 1'b0;
            if (block_out !== ZERO_CT) sb_moved = 1'b1;
        end
        check_eq("busy ready held", 128'(seen_ready), 128'd1);
        check_eq("busy no second result", 128'(sb_moved), 128'd0);

        // Reset in the middle of a block.
        expand_key(C1_KEY);
        block_in  = C1_PT;
        key       = C1_KEY;
        key_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        check_eq("abort ready", 128'(ready), 128'd0);
        check_eq("abort block_out", block_out, '0);
        check_eq("abort sboxw", sboxw, '0);
        seen_ready = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ready) seen_ready = 1'b1;
        end
        check_eq("abort no ready pulse", 128'(seen_ready), 128'd0);
        run_block("after abort", C1_PT, C1_KEY, C1_CT, 0);

        // Back-to-back: next start is driven at the edge following ready.
        run_block("b2b c1", C1_PT, C1_KEY, C1_CT, 0);
        run_block("b2b zero", '0, '0, ZERO_CT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_encipher.md
AES_ENCIPHER -- requirements
Module: aes_encipher

Interface
REQ-001 SHALL have one clock and one reset; reset_n is synchronous and active-high (asserted = 1), sampled on the rising edge of clk.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to encrypt block_in.
REQ-005 block_in  input  128  plaintext; byte 0 = bits [127:120], FIPS-197 column-major.
REQ-006 key  input  128  cipher key (round key 0), same key fed to aes_keymap.
REQ-007 key_ready  input  1  aes_keymap ready; round_key_1..10 valid while 1.
REQ-008 round_key_1 .. round_key_10  input  128 each  expanded round keys from aes_keymap.
REQ-009 sboxw  output  128  state word presented to the shared aes_sbox.
REQ-010 new_sboxw  input  128  bytewise S-box of sboxw, combinational return.
REQ-011 block_out  output  128  ciphertext.
REQ-012 ready  output  1  block_out valid; block idle.

Function
REQ-013 FSM states: IDLE, ROUND; 4-bit round counter rc (1..10).
REQ-014 IDLE: if start=1 and key_ready=1, load state <= block_in XOR key, rc <= 1, ready <= 0, go to ROUND.
REQ-015 IDLE: start=1 with key_ready=0 ignored; no state change, ready unchanged.
REQ-016 sboxw SHALL equal the state register combinationally in every state.
REQ-017 ROUND, rc=1..9: state <= MixColumns(ShiftRows(new_sboxw)) XOR round_key_rc; rc <= rc+1.
REQ-018 ROUND, rc=10: block_out <= ShiftRows(new_sboxw) XOR round_key_10; ready <= 1; go to IDLE; rc <= 0.
REQ-019 MixColumns SHALL use GF(2^8) with polynomial x^8+x^4+x^3+x+1 (xtime reduces by 8'h1b); all XORs are 128-bit, no carries.
REQ-020 Latency: 10 clock edges from the edge accepting start to ready=1; throughput one block per 11 cycles (accept, then 10 rounds).
REQ-021 start during ROUND SHALL be ignored; block_in and key are sampled only on the accepting edge.
REQ-022 round_key_* SHALL be treated as stable through ROUND; key_ready deasserting mid-operation does not abort (result undefined if keys change).
REQ-023 block_out and ready SHALL hold after completion until the next accepted start (ready falls on that edge) or reset.
REQ-024 start accepted on the same edge ready is high from a prior block SHALL be legal; back-to-back operation without extra idle cycle beyond IDLE.

Reset
REQ-025 reset_n=1 at an edge: FSM <= IDLE, rc <= 0, state <= 0, block_out <= 0, ready <= 0; takes priority over start and over an in-progress round.
REQ-026 reset mid-ROUND SHALL abort with no ready pulse; next start after reset release behaves as from power-up.
REQ-027 After reset release, ready stays 0 until the first completed encryption.

Verification
REQ-028 Zero vector: key=0, block_in=0, key_ready=1, start pulse -> ready=1 exactly 10 edges later, block_out=128'h66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-029 FIPS-197 C.1: key=128'h000102030405060708090a0b0c0d0e0f, block_in=128'h00112233445566778899aabbccddeeff -> block_out=128'h69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 Gating: start with key_ready=0 -> ready stays 0, sboxw unchanged for 12 cycles; then key_ready=1 plus start -> normal completion.
REQ-031 Busy ignore: second start with different block_in at round 5 -> first ciphertext produced unchanged at edge 10, no second result.
REQ-032 Reset abort: reset_n=1 at round 4 -> next edge ready=0, block_out=0, sboxw=0; subsequent start of C.1 vector yields correct ciphertext.
REQ-033 Back-to-back: start on the edge after ready rises with the C.1 vector, then the zero vector -> both ciphertexts correct, ready low for exactly 10 cycles between.
